proj_fm_window_buf: RTL and testbench

- Next-generation genome feature-map buffer: a ring of BUFFER_COUNT byte buffers.
- Write side fills one buffer at a time, WR_LANES bytes per beat, with valid/ready flow control.
- Read side streams sliding windows of WINDOW bytes at step STRIDE from each completed buffer, then releases that buffer.
- Sits between the genome byte stream and the minhash k-mer hashing stage.
- Adds over the previous fixed buffer: multi-lane writes, handshakes on both sides, early buffer close (tail of genome) and configurable stride.

---
 rtl/proj_fm_window_buf.sv | 175 +++++++++++++++++
 tb/tb_proj_fm_window_buf.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proj_fm_window_buf.sv
// Ring of byte buffers between the genome byte stream and the k-mer hashing stage.
// The write side fills one buffer per pass; the read side streams sliding windows from each completed buffer.
module proj_fm_window_buf #(
  parameter int BUFFER_COUNT = 4,
  parameter int DEPTH        = 64,
  parameter int DATA_BITS    = 8,
  parameter int WR_LANES     = 2,
  parameter int WINDOW       = 4,
  parameter int STRIDE       = 1
) (
  input  logic                                in_clk,
  input  logic                                in_rst,
  input  logic [WR_LANES*DATA_BITS-1:0]       in_wdata,
  input  logic                                in_wvalid,
  input  logic                                in_wlast,
  output logic                                out_wready,
  output logic [WINDOW*DATA_BITS-1:0]         out_rdata,
  output logic                                out_rvalid,
  input  logic                                in_rready,
  output logic                                out_rlast,
  output logic [$clog2(DEPTH)-1:0]            out_roffset,
  output logic [$clog2(BUFFER_COUNT+1)-1:0]   out_full_count
);

  localparam int IW = $clog2(BUFFER_COUNT);
  localparam int OW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(BUFFER_COUNT + 1);
  localparam int AW = $clog2(BUFFER_COUNT * DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;

  logic [DATA_BITS-1:0]     mem [BUFFER_COUNT*DEPTH];
  logic [BUFFER_COUNT-1:0]  full;
  logic [LW-1:0]            fill_len [BUFFER_COUNT];
  logic [IW-1:0]            wr_idx;
  logic [IW-1:0]            rd_idx;
  logic [IW-1:0]            rd_idx_nxt;
  logic [LW-1:0]            wptr;
  logic [LW-1:0]            wptr_nxt;
  logic [OW-1:0]            rd_off;
  logic [1:0]               state;
  logic                     wr_acc;
  logic                     wr_done;
  logic                     too_short;
  logic                     rel;
  logic                     last_nxt;
  logic [31:0]              sel_off;
  logic [31:0]              cur_len;
  logic [WINDOW*DATA_BITS-1:0] win_nxt;

  function automatic logic [AW-1:0] buf_addr(input logic [IW-1:0] idx, input logic [31:0] off);
    return AW'(32'(idx) * 32'(DEPTH) + off);
  endfunction

  assign out_wready  = !full[wr_idx];
  assign wr_acc      = in_wvalid && out_wready;
  assign wptr_nxt    = wptr + LW'(WR_LANES);
  assign wr_done     = wr_acc && (in_wlast || (wptr_nxt >= LW'(DEPTH)));
  assign rd_idx_nxt  = rd_idx + IW'(1);
  assign out_roffset = rd_off;

  // Write stage: lane 0 lands at the lowest address of the beat
  always_ff @(posedge in_clk) begin
    if (wr_acc) begin
      for (int l = 0; l < WR_LANES; l++) begin
        mem[buf_addr(wr_idx, 32'(wptr) + 32'(l))] <= in_wdata[l*DATA_BITS +: DATA_BITS];
      end
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      wptr   <= '0;
      wr_idx <= '0;
    end else if (wr_acc) begin
      if (wr_done) begin
        wptr   <= '0;
        wr_idx <= wr_idx + IW'(1);
      end else begin
        wptr <= wptr_nxt;
      end
    end
  end

  // Next window address: in VALID the following window is fetched so a handshake can reload on the same edge
  always_comb begin
    win_nxt  = '0;
    cur_len  = 32'(fill_len[rd_idx]);
    sel_off  = (state == S_VALID) ? 32'(rd_off) + 32'(STRIDE) : 32'(rd_off);
    last_nxt = (sel_off + 32'(STRIDE) + 32'(WINDOW)) > cur_len;
    for (int i = 0; i < WINDOW; i++) begin
      win_nxt[i*DATA_BITS +: DATA_BITS] = mem[buf_addr(rd_idx, sel_off + 32'(i))];
    end
  end

  assign too_short = cur_len < 32'(WINDOW);
  assign rel       = ((state == S_LOAD) && too_short) ||
                     ((state == S_VALID) && in_rready && out_rlast);

  // Full flags never collide: a completing write targets an empty slot, a release targets a full one
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      full           <= '0;
      out_full_count <= '0;
      for (int b = 0; b < BUFFER_COUNT; b++) begin
        fill_len[b] <= '0;
      end
    end else begin
      if (wr_done) begin
        full[wr_idx]     <= 1'b1;
        fill_len[wr_idx] <= wptr_nxt;
      end
      if (rel) begin
        full[rd_idx] <= 1'b0;
      end
      case ({wr_done, rel})
        2'b10:   out_full_count <= out_full_count + CW'(1);
        2'b01:   out_full_count <= out_full_count - CW'(1);
        default: out_full_count <= out_full_count;
      endcase
    end
  end

  // Read stage: window register and stream FSM
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state      <= S_IDLE;
      rd_idx     <= '0;
      rd_off     <= '0;
      out_rvalid <= 1'b0;
      out_rlast  <= 1'b0;
      out_rdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (full[rd_idx]) begin
            state  <= S_LOAD;
            rd_off <= '0;
          end
        end
        S_LOAD: begin
          if (too_short) begin
            state  <= S_IDLE;
            rd_idx <= rd_idx_nxt;
          end else begin
            out_rdata  <= win_nxt;
            out_rvalid <= 1'b1;
            out_rlast  <= last_nxt;
            state      <= S_VALID;
          end
        end
        S_VALID: begin
          if (in_rready) begin
            if (out_rlast) begin
              out_rvalid <= 1'b0;
              out_rlast  <= 1'b0;
              rd_off     <= '0;
              rd_idx     <= rd_idx_nxt;
              state      <= full[rd_idx_nxt] ? S_LOAD : S_IDLE;
            end else begin
              rd_off    <= OW'(sel_off);
              out_rdata <= win_nxt;
              out_rlast <= last_nxt;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proj_fm_window_buf.sv
// Directed bench for proj_fm_window_buf: 16-byte buffers, 2 lanes, 4-byte windows, stride 1.
module tb_proj_fm_window_buf;

  localparam int BC = 4;
  localparam int DP = 16;
  localparam int DB = 8;
  localparam int WL = 2;
  localparam int WN = 4;
  localparam int ST = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_wdata;
  logic        in_wvalid;
  logic        in_wlast;
  logic        out_wready;
  logic [31:0] out_rdata;
  logic        out_rvalid;
  logic        in_rready;
  logic        out_rlast;
  logic [3:0]  out_roffset;
  logic [2:0]  out_full_count;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic [7:0]  bc = 8'd0;
  logic [63:0] q[$];

  proj_fm_window_buf #(
    .BUFFER_COUNT(BC), .DEPTH(DP), .DATA_BITS(DB),
    .WR_LANES(WL), .WINDOW(WN), .STRIDE(ST)
  ) dut (
    .in_clk(clk), .in_rst(rst),
    .in_wdata(in_wdata), .in_wvalid(in_wvalid), .in_wlast(in_wlast), .out_wready(out_wready),
    .out_rdata(out_rdata), .out_rvalid(out_rvalid), .in_rready(in_rready), .out_rlast(out_rlast),
    .out_roffset(out_roffset), .out_full_count(out_full_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] pack(input logic l, input logic [3:0] off, input logic [31:0] d);
    return {27'd0, l, off, d};
  endfunction

  // Handshake recorder; inputs change only just after posedge, so the negedge view is what the next edge sees
  always @(negedge clk) begin
    if (!rst && out_rvalid && in_rready) q.push_back(pack(out_rlast, out_roffset, out_rdata));
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] ew(input logic [7:0] base, input int off, input int fill);
    logic [31:0] d;
    for (int i = 0; i < WN; i++) d[i*8 +: 8] = base + 8'(off + i);
    return pack((off + ST + WN) > fill, 4'(off), d);
  endfunction

  task automatic exp_buf(input logic [7:0] base, input int fill, input string tag);
    int n;
    n = (fill - WN) / ST + 1;
    for (int o = 0; o < n; o++) begin
      if (q.size() == 0) check(tag, 64'd0, ew(base, o * ST, fill));
      else check(tag, q.pop_front(), ew(base, o * ST, fill));
    end
  endtask

  task automatic put(input logic last);
    logic       ok;
    logic [7:0] hi;
    hi = bc + 8'd1;
    in_wdata  = {hi, bc};
    in_wlast  = last;
    in_wvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = out_wready;
      @(posedge clk);
    end
    if (!ok) check("put_timeout", 64'd0, 64'd1);
    #1;
    in_wvalid = 1'b0;
    in_wlast  = 1'b0;
    bc        = bc + 8'd2;
    acc_cyc   = cyc;
  endtask

  task automatic stream(input int beats, input logic close);
    for (int b = 0; b < beats; b++) put(close && (b == beats - 1));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!out_rvalid && out_full_count == 0) break;
    end
    check("drain_fc", 64'(out_full_count), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rvalid();
    for (int i = 0; i < 20 && !out_rvalid; i++) @(negedge clk);
    check("rvalid_seen", 64'(out_rvalid), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_basic(input string tag);
    logic [7:0] base;
    int         e;
    int         lat;
    q.delete();
    in_rready = 1'b1;
    base = bc;
    stream(8, 1'b0);
    e = acc_cyc;
    lat = -1;
    for (int i = 0; i < 10 && lat < 0; i++) begin
      @(negedge clk);
      if (out_rvalid) lat = cyc - e;
    end
    check({tag, "_lat"}, 64'(lat), 64'd2);
    wait_idle();
    exp_buf(base, 16, {tag, "_win"});
    check({tag, "_extra"}, 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [63:0] pv;
    logic [63:0] cur;
    logic        hp;
    logic        stalled;
    logic        seen;
    logic        got;
    int          acc;
    int          hs;
    int          e;
    int          zero_at;

    rst = 1'b1; in_wdata = '0; in_wvalid = 1'b0; in_wlast = 1'b0; in_rready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rvalid", 64'(out_rvalid), 64'd0);
    check("rst_rdata", 64'(out_rdata), 64'd0);
    check("rst_fc", 64'(out_full_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_wready", 64'(out_wready), 64'd1);
    check("rst_rlast", 64'(out_rlast), 64'd0);
    check("rst_roff", 64'(out_roffset), 64'd0);

    // basic stream: bytes 0x00..0x0F
    run_basic("s1");

    // full ring with reader stalled, then drain
    q.delete();
    in_rready = 1'b0;
    b0 = bc;
    acc = 0;
    in_wvalid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      b1 = bc + 8'd1;
      in_wdata = {b1, bc};
      @(negedge clk);
      if (!out_wready) break;
      @(posedge clk);
      #1;
      acc++;
      bc = bc + 8'd2;
    end
    in_wvalid = 1'b0;
    check("bp_beats", 64'(acc), 64'd32);
    check("bp_fc", 64'(out_full_count), 64'd4);
    check("bp_wready", 64'(out_wready), 64'd0);
    check("bp_head", pack(out_rlast, out_roffset, out_rdata), ew(b0, 0, 16));
    @(posedge clk);
    #1;
    in_rready = 1'b1;
    hs = 0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (out_rvalid && in_rready) begin
        hs++;
        if (hs == 13) begin
          check("bp_wr_hold", 64'(out_wready), 64'd0);
          @(negedge clk);
          check("bp_wr_back", 64'(out_wready), 64'd1);
          got = 1'b1;
        end
      end
    end
    if (!got) check("bp_timeout", 64'd0, 64'd1);
    wait_idle();
    for (int b = 0; b < 4; b++) exp_buf(b0 + 8'(16 * b), 16, "bp_win");
    check("bp_extra", 64'(q.size()), 64'd0);

    // early close at 6 bytes, then a 4-byte buffer starting from offset 0
    q.delete();
    b0 = bc;
    stream(3, 1'b1);
    b1 = bc;
    stream(2, 1'b1);
    wait_idle();
    exp_buf(b0, 6, "ec_win");
    exp_buf(b1, 4, "ec_next");
    check("ec_extra", 64'(q.size()), 64'd0);

    // short buffer (2 bytes) is released without emitting a window
    q.delete();
    stream(1, 1'b1);
    e = acc_cyc;
    zero_at = -1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_rvalid) seen = 1'b1;
      if (zero_at < 0 && out_full_count == 0) zero_at = cyc - e;
    end
    check("sb_rvalid", 64'(seen), 64'd0);
    check("sb_clear", 64'(zero_at), 64'd2);
    check("sb_extra", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;

    // reader stalls every other cycle
    q.delete();
    in_rready = 1'b0;
    b0 = bc;
    stream(8, 1'b0);
    wait_rvalid();
    hp = 1'b0;
    stalled = 1'b0;
    pv = '0;
    for (int k = 0; k < 80; k++) begin
      in_rready = (k % 2) == 1;
      @(negedge clk);
      if (out_rvalid) begin
        cur = pack(out_rlast, out_roffset, out_rdata);
        if (hp && stalled) check("st_hold", cur, pv);
        pv = cur;
        hp = 1'b1;
        stalled = !in_rready;
      end else begin
        hp = 1'b0;
      end
      if (!out_rvalid && out_full_count == 0) break;
      @(posedge clk);
      #1;
    end
    in_rready = 1'b1;
    @(posedge clk);
    #1;
    exp_buf(b0, 16, "st_win");
    check("st_extra", 64'(q.size()), 64'd0);

    // reset in the middle of a buffer's windows
    q.delete();
    in_rready = 1'b0;
    stream(8, 1'b0);
    wait_rvalid();
    in_rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_rready = 1'b0;
    @(negedge clk);
    check("rs_pre_off", 64'(out_roffset), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    check("rs_rvalid", 64'(out_rvalid), 64'd0);
    check("rs_rlast", 64'(out_rlast), 64'd0);
    check("rs_rdata", 64'(out_rdata), 64'd0);
    check("rs_roff", 64'(out_roffset), 64'd0);
    check("rs_fc", 64'(out_full_count), 64'd0);
    check("rs_wready", 64'(out_wready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    bc = 8'd0;
    run_basic("rs");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
